// File: rtl/control_pkg.sv
// Shared definitions for the multi-cycle control unit.
// Holds the state encoding, the opcode map, the ALU operation codes
// and the operand-select codes used by the A and B ALU input muxes.
package control_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'h0,
      DECODE   = 4'h1,
      EXEC_R   = 4'h2,
      EXEC_I   = 4'h3,
      ALU_WB   = 4'h4,
      MEM_ADDR = 4'h5,
      MEM_RD   = 4'h6,
      MEM_WB   = 4'h7,
      MEM_WR   = 4'h8,
      BRANCH   = 4'h9,
      HALT     = 4'hA
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_ADDI = 4'h4;
   localparam logic [3:0] OP_LW   = 4'h5;
   localparam logic [3:0] OP_SW   = 4'h6;
   localparam logic [3:0] OP_BEQ  = 4'h7;
   localparam logic [3:0] OP_BNE  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_OR  = 4'h3;

   localparam logic [1:0] SRCA_PC   = 2'd0;
   localparam logic [1:0] SRCA_TWO  = 2'd1;
   localparam logic [1:0] SRCA_AREG = 2'd2;
   localparam logic [1:0] SRCA_IMM  = 2'd3;

   localparam logic [1:0] SRCB_BREG = 2'd0;
   localparam logic [1:0] SRCB_TWO  = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;

   // An opcode is legal if it is one of the nine datapath instructions
   // (0..8) or the explicit HALT; everything from 9 to E is undefined.
   function automatic logic isLegalOpcode(input logic [3:0] opcode);
      return (opcode <= OP_BNE) || (opcode == OP_HALT);
   endfunction

endpackage

// File: rtl/control_output_decoder.sv
// Combinational control-signal decoder for the multi-cycle datapath.
// Turns the current state, the IR opcode and the live ALU/memory flags
// into operand selects, ALU operation, PC source and all write enables.
// Ports:
//   reset        - while high, every write enable and strobe is forced low
//   stateCur     - current FSM state
//   opcode       - IR[15:12]
//   zero         - ALU zero flag for the branch compare in progress
//   memReady     - memory handshake, gates the fetch and data accesses
//   aluSrcA/B, aluOp, pcSrc, pcWrite, irWrite, iorD, memRead, memWrite,
//   regWrite, memToReg - datapath controls
//   halted       - high while the FSM sits in HALT
module control_output_decoder
   import control_pkg::*;
(
   input  logic       reset,
   input  state_t     stateCur,
   input  logic [3:0] opcode,
   input  logic       zero,
   input  logic       memReady,
   output logic [1:0] aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [3:0] aluOp,
   output logic       pcSrc,
   output logic       pcWrite,
   output logic       irWrite,
   output logic       iorD,
   output logic       memRead,
   output logic       memWrite,
   output logic       regWrite,
   output logic       memToReg,
   output logic       halted
);

   // Everything starts at zero so each state only names the controls it
   // actually asserts. Reset is applied last so a reset in the middle of
   // an instruction can never let a write or memory strobe slip through.
   always_comb begin
      aluSrcA  = SRCA_PC;
      aluSrcB  = SRCB_BREG;
      aluOp    = ALU_ADD;
      pcSrc    = 1'b0;
      pcWrite  = 1'b0;
      irWrite  = 1'b0;
      iorD     = 1'b0;
      memRead  = 1'b0;
      memWrite = 1'b0;
      regWrite = 1'b0;
      memToReg = 1'b0;
      halted   = 1'b0;

      case (stateCur)
         FETCH: begin
            memRead = 1'b1;
            aluSrcA = SRCA_PC;
            aluSrcB = SRCB_TWO;
            aluOp   = ALU_ADD;
            irWrite = memReady;
            pcWrite = memReady;
         end
         DECODE: begin
            aluSrcA = SRCA_PC;
            aluSrcB = SRCB_IMM;
            aluOp   = ALU_ADD;
         end
         EXEC_R: begin
            aluSrcA = SRCA_AREG;
            aluSrcB = SRCB_BREG;
            aluOp   = {2'b00, opcode[1:0]};
         end
         EXEC_I, MEM_ADDR: begin
            aluSrcA = SRCA_AREG;
            aluSrcB = SRCB_IMM;
            aluOp   = ALU_ADD;
         end
         ALU_WB: begin
            regWrite = 1'b1;
            memToReg = 1'b0;
         end
         MEM_RD: begin
            iorD    = 1'b1;
            memRead = 1'b1;
         end
         MEM_WB: begin
            regWrite = 1'b1;
            memToReg = 1'b1;
         end
         MEM_WR: begin
            iorD     = 1'b1;
            memWrite = 1'b1;
         end
         BRANCH: begin
            aluSrcA = SRCA_AREG;
            aluSrcB = SRCB_BREG;
            aluOp   = ALU_SUB;
            pcSrc   = 1'b1;
            pcWrite = (opcode == OP_BEQ) ? zero : ~zero;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: begin
            halted = 1'b0;
         end
      endcase

      if (reset) begin
         pcWrite  = 1'b0;
         irWrite  = 1'b0;
         memRead  = 1'b0;
         memWrite = 1'b0;
         regWrite = 1'b0;
      end
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Control unit for the 16-bit multi-cycle datapath.
// Sequences each instruction through fetch/decode/execute/memory/writeback,
// stalls on the memory handshake, halts on HALT or an undefined opcode and
// counts retired instructions.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   input_opcode        - IR[15:12]
//   input_Zero          - ALU zero flag, same cycle
//   input_mem_ready     - memory read data valid / write accepted
//   output_*            - datapath controls (see control_output_decoder)
//   output_state        - current state encoding for debug
//   output_halted       - high while in HALT
//   output_illegal      - sticky undefined-opcode flag
//   output_instr_count  - retired instruction count, wraps
module multicycle_control_fsm
   import control_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       input_opcode,
   input  logic             input_Zero,
   input  logic             input_mem_ready,
   output logic [1:0]       output_ALUSrcA,
   output logic [1:0]       output_ALUSrcB,
   output logic [3:0]       output_ALUOp,
   output logic             output_PCSrc,
   output logic             output_PCWrite,
   output logic             output_IRWrite,
   output logic             output_IorD,
   output logic             output_MemRead,
   output logic             output_MemWrite,
   output logic             output_RegWrite,
   output logic             output_MemtoReg,
   output logic [3:0]       output_state,
   output logic             output_halted,
   output logic             output_illegal,
   output logic [CNT_W-1:0] output_instr_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   state_t           stateReg;
   logic             illegalReg;
   logic [CNT_W-1:0] instrCount;

   // State register, next-state selection, sticky illegal flag and the
   // retired-instruction counter all live here. A retiring state bumps the
   // counter on the same edge that returns to FETCH; HALT never counts and
   // only reset gets the machine out of it.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg   <= FETCH;
         illegalReg <= 1'b0;
         instrCount <= '0;
      end else begin
         case (stateReg)
            FETCH: begin
               if (input_mem_ready) begin
                  stateReg <= DECODE;
               end
            end
            DECODE: begin
               if (!isLegalOpcode(input_opcode)) begin
                  stateReg   <= HALT;
                  illegalReg <= 1'b1;
               end else if (input_opcode <= OP_OR) begin
                  stateReg <= EXEC_R;
               end else if (input_opcode == OP_ADDI) begin
                  stateReg <= EXEC_I;
               end else if ((input_opcode == OP_LW) || (input_opcode == OP_SW)) begin
                  stateReg <= MEM_ADDR;
               end else if ((input_opcode == OP_BEQ) || (input_opcode == OP_BNE)) begin
                  stateReg <= BRANCH;
               end else begin
                  stateReg <= HALT;
               end
            end
            EXEC_R, EXEC_I: begin
               stateReg <= ALU_WB;
            end
            MEM_ADDR: begin
               stateReg <= (input_opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
               if (input_mem_ready) begin
                  stateReg <= MEM_WB;
               end
            end
            MEM_WR: begin
               if (input_mem_ready) begin
                  stateReg   <= FETCH;
                  instrCount <= instrCount + CNT_ONE;
               end
            end
            ALU_WB, MEM_WB, BRANCH: begin
               stateReg   <= FETCH;
               instrCount <= instrCount + CNT_ONE;
            end
            HALT: begin
               stateReg <= HALT;
            end
            default: begin
               stateReg <= FETCH;
            end
         endcase
      end
   end

   // All datapath controls are a pure decode of the state register plus
   // the live opcode and flags, so they sit in their own block.
   control_output_decoder uDecoder (
      .reset    (reset),
      .stateCur (stateReg),
      .opcode   (input_opcode),
      .zero     (input_Zero),
      .memReady (input_mem_ready),
      .aluSrcA  (output_ALUSrcA),
      .aluSrcB  (output_ALUSrcB),
      .aluOp    (output_ALUOp),
      .pcSrc    (output_PCSrc),
      .pcWrite  (output_PCWrite),
      .irWrite  (output_IRWrite),
      .iorD     (output_IorD),
      .memRead  (output_MemRead),
      .memWrite (output_MemWrite),
      .regWrite (output_RegWrite),
      .memToReg (output_MemtoReg),
      .halted   (output_halted)
   );

   // Debug and status views of the internal registers.
   assign output_state       = stateReg;
   assign output_illegal     = illegalReg;
   assign output_instr_count = instrCount;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed testbench for multicycle_control_fsm. A second instance with a
// 3-bit counter shares the same stimulus so counter wrap is reachable in a
// short run.
module tb_multicycle_control_fsm;

   logic        clk;
   logic        reset;
   logic [3:0]  opcode;
   logic        zero;
   logic        memReady;

   logic [1:0]  aluSrcA;
   logic [1:0]  aluSrcB;
   logic [3:0]  aluOp;
   logic        pcSrc;
   logic        pcWrite;
   logic        irWrite;
   logic        iorD;
   logic        memRead;
   logic        memWrite;
   logic        regWrite;
   logic        memToReg;
   logic [3:0]  stateDbg;
   logic        halted;
   logic        illegal;
   logic [15:0] instrCount;

   logic [1:0]  sAluSrcA;
   logic [1:0]  sAluSrcB;
   logic [3:0]  sAluOp;
   logic        sPcSrc;
   logic        sPcWrite;
   logic        sIrWrite;
   logic        sIorD;
   logic        sMemRead;
   logic        sMemWrite;
   logic        sRegWrite;
   logic        sMemToReg;
   logic [3:0]  sStateDbg;
   logic        sHalted;
   logic        sIllegal;
   logic [2:0]  sInstrCount;

   logic [4:0]  enables;

   int totalChecks;
   int badChecks;

   assign enables = {pcWrite, irWrite, memRead, memWrite, regWrite};

   multicycle_control_fsm #(.CNT_W(16)) dut (
      .clk                (clk),
      .reset              (reset),
      .input_opcode       (opcode),
      .input_Zero         (zero),
      .input_mem_ready    (memReady),
      .output_ALUSrcA     (aluSrcA),
      .output_ALUSrcB     (aluSrcB),
      .output_ALUOp       (aluOp),
      .output_PCSrc       (pcSrc),
      .output_PCWrite     (pcWrite),
      .output_IRWrite     (irWrite),
      .output_IorD        (iorD),
      .output_MemRead     (memRead),
      .output_MemWrite    (memWrite),
      .output_RegWrite    (regWrite),
      .output_MemtoReg    (memToReg),
      .output_state       (stateDbg),
      .output_halted      (halted),
      .output_illegal     (illegal),
      .output_instr_count (instrCount)
   );

   multicycle_control_fsm #(.CNT_W(3)) dutSmall (
      .clk                (clk),
      .reset              (reset),
      .input_opcode       (opcode),
      .input_Zero         (zero),
      .input_mem_ready    (memReady),
      .output_ALUSrcA     (sAluSrcA),
      .output_ALUSrcB     (sAluSrcB),
      .output_ALUOp       (sAluOp),
      .output_PCSrc       (sPcSrc),
      .output_PCWrite     (sPcWrite),
      .output_IRWrite     (sIrWrite),
      .output_IorD        (sIorD),
      .output_MemRead     (sMemRead),
      .output_MemWrite    (sMemWrite),
      .output_RegWrite    (sRegWrite),
      .output_MemtoReg    (sMemToReg),
      .output_state       (sStateDbg),
      .output_halted      (sHalted),
      .output_illegal     (sIllegal),
      .output_instr_count (sInstrCount)
   );

   // Free-running clock, rising edges at 5, 15, 25 ns ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Move to just after the next rising edge so registered values are settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the DUT inputs and give the combinational decode time to settle.
   task automatic applyStimulus(input logic [3:0] op, input logic ready, input logic z);
      opcode   = op;
      memReady = ready;
      zero     = z;
      #1;
   endtask

   // One comparison: count it, and count plus report it if it disagrees.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalChecks++;
      assert (observed === expected)
      else begin
         badChecks++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Linear sequence of directed steps with hand-computed expectations.
   initial begin
      totalChecks = 0;
      badChecks   = 0;
      reset       = 1'b1;
      applyStimulus(4'h0, 1'b1, 1'b0);

      tick();
      checkOutput("reset_en_c1", {27'd0, enables}, 32'h0);
      checkOutput("reset_state", {28'd0, stateDbg}, 32'h0);
      tick();
      checkOutput("reset_en_c2", {27'd0, enables}, 32'h0);
      checkOutput("reset_count", {16'd0, instrCount}, 32'h0);
      checkOutput("reset_illegal", {31'd0, illegal}, 32'h0);
      checkOutput("reset_halted", {31'd0, halted}, 32'h0);
      reset = 1'b0;
      #1;
      checkOutput("fetch_en", {27'd0, enables}, 32'b11100);
      checkOutput("fetch_srcb", {30'd0, aluSrcB}, 32'd1);
      checkOutput("fetch_iord", {31'd0, iorD}, 32'd0);

      // ADD: 0 -> 1 -> 2 -> 4 -> 0
      tick();
      checkOutput("add_s1", {28'd0, stateDbg}, 32'd1);
      checkOutput("add_dec_srcb", {30'd0, aluSrcB}, 32'd2);
      checkOutput("add_dec_en", {27'd0, enables}, 32'h0);
      tick();
      checkOutput("add_s2", {28'd0, stateDbg}, 32'd2);
      checkOutput("add_exe_srca", {30'd0, aluSrcA}, 32'd2);
      checkOutput("add_exe_srcb", {30'd0, aluSrcB}, 32'd0);
      checkOutput("add_exe_aluop", {28'd0, aluOp}, 32'd0);
      checkOutput("add_exe_regwr", {31'd0, regWrite}, 32'd0);
      tick();
      checkOutput("add_s4", {28'd0, stateDbg}, 32'd4);
      checkOutput("add_wb_regwr", {31'd0, regWrite}, 32'd1);
      checkOutput("add_wb_m2r", {31'd0, memToReg}, 32'd0);
      checkOutput("add_cnt_before", {16'd0, instrCount}, 32'd0);
      tick();
      checkOutput("add_s0", {28'd0, stateDbg}, 32'd0);
      checkOutput("add_cnt", {16'd0, instrCount}, 32'd1);

      // OR: the R-type ALU op follows opcode[1:0]
      applyStimulus(4'h3, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("or_s2", {28'd0, stateDbg}, 32'd2);
      checkOutput("or_aluop", {28'd0, aluOp}, 32'd3);
      tick();
      tick();
      checkOutput("or_cnt", {16'd0, instrCount}, 32'd2);

      // ADDI: 0 -> 1 -> 3 -> 4 -> 0
      applyStimulus(4'h4, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("addi_s3", {28'd0, stateDbg}, 32'd3);
      checkOutput("addi_srcb", {30'd0, aluSrcB}, 32'd2);
      tick();
      checkOutput("addi_s4", {28'd0, stateDbg}, 32'd4);
      tick();
      checkOutput("addi_cnt", {16'd0, instrCount}, 32'd3);

      // LW with three stalled cycles in MEM_RD: 0,1,5,6,6,6,6,7 = 8 cycles
      applyStimulus(4'h5, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("lw_s5", {28'd0, stateDbg}, 32'd5);
      checkOutput("lw_addr_srca", {30'd0, aluSrcA}, 32'd2);
      checkOutput("lw_addr_srcb", {30'd0, aluSrcB}, 32'd2);
      applyStimulus(4'h5, 1'b0, 1'b0);
      tick();
      checkOutput("lw_s6", {28'd0, stateDbg}, 32'd6);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("lw_stall_state", {28'd0, stateDbg}, 32'd6);
         checkOutput("lw_stall_memrd", {31'd0, memRead}, 32'd1);
         checkOutput("lw_stall_iord", {31'd0, iorD}, 32'd1);
      end
      applyStimulus(4'h5, 1'b1, 1'b0);
      tick();
      checkOutput("lw_s7", {28'd0, stateDbg}, 32'd7);
      checkOutput("lw_m2r", {31'd0, memToReg}, 32'd1);
      checkOutput("lw_regwr", {31'd0, regWrite}, 32'd1);
      tick();
      checkOutput("lw_s0", {28'd0, stateDbg}, 32'd0);
      checkOutput("lw_cnt", {16'd0, instrCount}, 32'd4);

      // SW with one stalled fetch cycle
      applyStimulus(4'h6, 1'b0, 1'b0);
      checkOutput("fstall_en", {27'd0, enables}, 32'b00100);
      tick();
      checkOutput("fstall_state", {28'd0, stateDbg}, 32'd0);
      applyStimulus(4'h6, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("sw_s5", {28'd0, stateDbg}, 32'd5);
      tick();
      checkOutput("sw_s8", {28'd0, stateDbg}, 32'd8);
      checkOutput("sw_memwr", {31'd0, memWrite}, 32'd1);
      checkOutput("sw_iord", {31'd0, iorD}, 32'd1);
      tick();
      checkOutput("sw_s0", {28'd0, stateDbg}, 32'd0);
      checkOutput("sw_cnt", {16'd0, instrCount}, 32'd5);

      // BEQ with Zero=1 takes the branch
      applyStimulus(4'h7, 1'b1, 1'b1);
      tick();
      tick();
      checkOutput("beq_s9", {28'd0, stateDbg}, 32'd9);
      checkOutput("beq_pcwr", {31'd0, pcWrite}, 32'd1);
      checkOutput("beq_pcsrc", {31'd0, pcSrc}, 32'd1);
      checkOutput("beq_aluop", {28'd0, aluOp}, 32'd1);
      checkOutput("beq_srca", {30'd0, aluSrcA}, 32'd2);
      tick();
      checkOutput("beq_cnt", {16'd0, instrCount}, 32'd6);

      // BNE with Zero=1 does not branch, Zero=0 would
      applyStimulus(4'h8, 1'b1, 1'b1);
      tick();
      tick();
      checkOutput("bne_s9", {28'd0, stateDbg}, 32'd9);
      checkOutput("bne_pcwr_z1", {31'd0, pcWrite}, 32'd0);
      checkOutput("bne_pcsrc", {31'd0, pcSrc}, 32'd1);
      applyStimulus(4'h8, 1'b1, 1'b0);
      checkOutput("bne_pcwr_z0", {31'd0, pcWrite}, 32'd1);
      tick();
      checkOutput("bne_cnt", {16'd0, instrCount}, 32'd7);

      // Illegal opcode 0xB halts with the sticky flag
      applyStimulus(4'hB, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("ill_sA", {28'd0, stateDbg}, 32'hA);
      checkOutput("ill_flag", {31'd0, illegal}, 32'd1);
      checkOutput("ill_halted", {31'd0, halted}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("ill_hold_state", {28'd0, stateDbg}, 32'hA);
         checkOutput("ill_hold_en", {27'd0, enables}, 32'h0);
      end
      checkOutput("ill_cnt", {16'd0, instrCount}, 32'd7);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checkOutput("ill_rst_flag", {31'd0, illegal}, 32'd0);
      checkOutput("ill_rst_halted", {31'd0, halted}, 32'd0);
      checkOutput("ill_rst_state", {28'd0, stateDbg}, 32'd0);
      checkOutput("ill_rst_cnt", {16'd0, instrCount}, 32'd0);

      // Explicit HALT is not illegal
      applyStimulus(4'hF, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("halt_sA", {28'd0, stateDbg}, 32'hA);
      checkOutput("halt_halted", {31'd0, halted}, 32'd1);
      checkOutput("halt_illegal", {31'd0, illegal}, 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;

      // Reset in the middle of a stalled LW suppresses the read strobe
      applyStimulus(4'h5, 1'b1, 1'b0);
      tick();
      tick();
      applyStimulus(4'h5, 1'b0, 1'b0);
      tick();
      checkOutput("mid_s6", {28'd0, stateDbg}, 32'd6);
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_en", {27'd0, enables}, 32'h0);
      tick();
      reset = 1'b0;
      #1;
      checkOutput("mid_state", {28'd0, stateDbg}, 32'd0);
      checkOutput("mid_cnt", {16'd0, instrCount}, 32'd0);

      // Eight not-taken BEQs: the 3-bit counter wraps 7 -> 0
      applyStimulus(4'h7, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         tick();
         tick();
         tick();
      end
      checkOutput("wrap_small_7", {29'd0, sInstrCount}, 32'd7);
      checkOutput("wrap_big_7", {16'd0, instrCount}, 32'd7);
      tick();
      tick();
      tick();
      checkOutput("wrap_small_0", {29'd0, sInstrCount}, 32'd0);
      checkOutput("wrap_big_8", {16'd0, instrCount}, 32'd8);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
